// File: rtl/ov7670_fb_writer_if.sv
// Camera DVP input and framebuffer write bus of the OV7670 framebuffer writer.
// The master side is the writer: it consumes the camera stream and drives the write strobe.
interface ov7670_fb_writer_if #(
    parameter int ADDR_W = 17
);
    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_d;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [15:0]       fb_data;

    modport master (
        input  cam_vsync, cam_href, cam_d,
        output fb_we, fb_addr, fb_data
    );

    modport slave (
        output cam_vsync, cam_href, cam_d,
        input  fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/ov7670_fb_writer.sv
// OV7670 DVP capture into a linear RGB565 framebuffer: byte pairs become pixels,
// and anything beyond the active window is dropped and flagged in a sticky error.
module ov7670_fb_writer #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 17
) (
    input  logic               cam_clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               continuous,
    ov7670_fb_writer_if.master bus,
    output logic               busy,
    output logic               frame_done,
    output logic               err
);
    localparam int COL_W  = $clog2(H_ACTIVE + 1);
    localparam int LINE_W = $clog2(V_ACTIVE + 1);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_ACTIVE);
    localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic               vs_q_r, vs_qq_r, href_q_r, href_qq_r;
    logic [7:0]         d_q_r;
    logic [7:0]         hi_byte_r, hi_byte_s;
    logic               phase_r, phase_s;
    logic [COL_W-1:0]   col_r, col_s;
    logic [LINE_W-1:0]  line_r, line_s;
    logic [ADDR_W-1:0]  line_base_r, line_base_s;
    logic               fb_we_r, fb_we_s;
    logic [ADDR_W-1:0]  fb_addr_r, fb_addr_s;
    logic [15:0]        fb_data_r, fb_data_s;
    logic               busy_r, busy_s;
    logic               frame_done_r, frame_done_s;
    logic               err_r, err_s;
    logic               vs_rise_s, vs_fall_s, href_fall_s, in_bounds_s;

    assign vs_rise_s   = vs_q_r & ~vs_qq_r;
    assign vs_fall_s   = ~vs_q_r & vs_qq_r;
    assign href_fall_s = ~href_q_r & href_qq_r;
    assign in_bounds_s = (col_r < COL_MAX) && (line_r < LINE_MAX);

    assign bus.fb_we   = fb_we_r;
    assign bus.fb_addr = fb_addr_r;
    assign bus.fb_data = fb_data_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign err         = err_r;

    // State register.
    always_ff @(posedge cam_clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; arm is only re-examined at frame end while capturing.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arm) state_s = ST_WAIT_VS;
                else     state_s = ST_IDLE;
            end
            ST_WAIT_VS: begin
                if (!arm)          state_s = ST_IDLE;
                else if (vs_fall_s) state_s = ST_CAPTURE;
                else               state_s = ST_WAIT_VS;
            end
            ST_CAPTURE: begin
                if (vs_rise_s) state_s = (continuous && arm) ? ST_WAIT_VS : ST_DONE;
                else           state_s = ST_CAPTURE;
            end
            ST_DONE: begin
                if (!arm) state_s = ST_IDLE;
                else      state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output and datapath next values: pixel assembly, line bookkeeping, error flag.
    always_comb begin
        hi_byte_s    = hi_byte_r;
        phase_s      = phase_r;
        col_s        = col_r;
        line_s       = line_r;
        line_base_s  = line_base_r;
        fb_we_s      = 1'b0;
        fb_addr_s    = fb_addr_r;
        fb_data_s    = fb_data_r;
        err_s        = err_r;
        frame_done_s = 1'b0;
        busy_s       = (state_s == ST_WAIT_VS) || (state_s == ST_CAPTURE);
        case (state_r)
            ST_IDLE: begin
                if (arm) err_s = 1'b0;
                else     err_s = err_r;
            end
            ST_WAIT_VS: begin
                if (vs_fall_s) begin
                    col_s       = '0;
                    line_s      = '0;
                    line_base_s = '0;
                    phase_s     = 1'b0;
                end else begin
                    phase_s     = phase_r;
                end
            end
            ST_CAPTURE: begin
                if (href_q_r) begin
                    if (!phase_r) begin
                        hi_byte_s = d_q_r;
                        phase_s   = 1'b1;
                    end else begin
                        phase_s = 1'b0;
                        // A pixel completing on the frame-ending edge is dropped so the
                        // strobe never lands outside CAPTURE.
                        if (in_bounds_s && !vs_rise_s) begin
                            fb_we_s   = 1'b1;
                            fb_addr_s = line_base_r + ADDR_W'(col_r);
                            fb_data_s = {hi_byte_r, d_q_r};
                            col_s     = col_r + COL_W'(1);
                        end else begin
                            err_s = 1'b1;
                        end
                    end
                end else if (href_fall_s) begin
                    if (phase_r) err_s = 1'b1;
                    else         err_s = err_r;
                    phase_s = 1'b0;
                    col_s   = '0;
                    if (line_r < LINE_MAX) begin
                        line_base_s = line_base_r + LINE_STEP;
                        line_s      = line_r + LINE_W'(1);
                    end else begin
                        line_s      = line_r;
                    end
                end else begin
                    phase_s = phase_r;
                end
                if (vs_rise_s) frame_done_s = 1'b1;
                else           frame_done_s = 1'b0;
            end
            ST_DONE: begin
                frame_done_s = 1'b0;
            end
            default: begin
                frame_done_s = 1'b0;
            end
        endcase
    end

    // Input sampling, datapath and registered outputs.
    always_ff @(posedge cam_clk or posedge rst) begin
        if (rst) begin
            vs_q_r       <= 1'b0;
            vs_qq_r      <= 1'b0;
            href_q_r     <= 1'b0;
            href_qq_r    <= 1'b0;
            d_q_r        <= 8'h00;
            hi_byte_r    <= 8'h00;
            phase_r      <= 1'b0;
            col_r        <= '0;
            line_r       <= '0;
            line_base_r  <= '0;
            fb_we_r      <= 1'b0;
            fb_addr_r    <= '0;
            fb_data_r    <= 16'h0000;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            vs_q_r       <= bus.cam_vsync;
            vs_qq_r      <= vs_q_r;
            href_q_r     <= bus.cam_href;
            href_qq_r    <= href_q_r;
            d_q_r        <= bus.cam_d;
            hi_byte_r    <= hi_byte_s;
            phase_r      <= phase_s;
            col_r        <= col_s;
            line_r       <= line_s;
            line_base_r  <= line_base_s;
            fb_we_r      <= fb_we_s;
            fb_addr_r    <= fb_addr_s;
            fb_data_r    <= fb_data_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
            err_r        <= err_s;
        end
    end
endmodule

// File: doc/ov7670_fb_writer.md
Name: ov7670_fb_writer

Overview:
- Camera-side writer into the shared RGB565 framebuffer that the ILI9341 SPI driver reads out.
- Receives the OV7670 8-bit DVP stream (VSYNC, HREF, D[7:0]) clocked by the camera pixel clock.
- Assembles each pair of bytes into one 16-bit RGB565 pixel and issues registered write strobes with linear addresses.
- Handles frame arming, single-shot or continuous capture, and over-length line/frame protection.

Parameters:
H_ACTIVE, 320, pixels per line written to framebuffer
V_ACTIVE, 240, lines per frame written to framebuffer
ADDR_W, 17, framebuffer address width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE)

Ports:
cam_clk  input  1  camera pixel clock; sole clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
arm  input  1  level; capture permitted while high
continuous  input  1  1 = capture every frame, 0 = stop after one frame
cam_vsync  input  1  OV7670 VSYNC, high pulse marks frame start
cam_href  input  1  OV7670 HREF, high during valid line bytes
cam_d  input  8  OV7670 data byte
fb_we  output  1  framebuffer write strobe, one cycle per pixel
fb_addr  output  ADDR_W  framebuffer write address
fb_data  output  16  RGB565 pixel, first byte in [15:8], second byte in [7:0]
busy  output  1  high in WAIT_VS or CAPTURE
frame_done  output  1  one-cycle pulse at end of a captured frame
err  output  1  sticky: over-length line, excess lines, or odd byte count

Behaviour:
- Reset: state IDLE; fb_we=0, fb_addr=0, fb_data=0, busy=0, frame_done=0, err=0; byte phase, column, line, and line_base counters all 0.
- Inputs are sampled once per cam_clk into registers vs_q, href_q, d_q. All edge detects use current sample vs previous sample.
- FSM:
  - IDLE: if arm=1, go to WAIT_VS; clear err on this entry.
  - WAIT_VS: on falling edge of vsync (frame start), go to CAPTURE and clear col, line, line_base, phase. If arm=0, go to IDLE.
  - CAPTURE: assemble pixels (below). A vsync rising edge ends the frame: pulse frame_done. Then go to WAIT_VS if continuous=1 and arm=1, otherwise go to DONE.
  - CAPTURE with arm dropped: the frame in progress completes; arm is checked only at frame end.
  - DONE: return to IDLE when arm=0; otherwise stay.
- Pixel assembly (CAPTURE, href_q=1):
  - phase=0: latch d_q into hi_byte, set phase=1.
  - phase=1: set phase=0; a pixel is complete.
  - Write condition: the pixel is written only if col<H_ACTIVE and line<V_ACTIVE. Then fb_we=1 on the next cycle, with fb_data={hi_byte,d_q} and fb_addr=line_base+col. col increments.
  - Dropped pixel: if either bound is exceeded, no write occurs and err is set.
- Latency: fb_we rises exactly 1 cycle after the second byte is sampled, i.e. 2 cycles after it appears on cam_d.
- Line end (href falling edge in CAPTURE):
  - If phase=1, discard the half pixel, set err, and reset phase to 0.
  - If line<V_ACTIVE, add H_ACTIVE to line_base.
  - line increments, saturating at V_ACTIVE. col returns to 0.
- Short lines: lines shorter than H_ACTIVE leave the remaining addresses unwritten; no error is flagged.
- Address arithmetic: ADDR_W bits, no wrap. The maximum address is H_ACTIVE*V_ACTIVE-1 = 76799.
- fb_we is never asserted outside CAPTURE. fb_data and fb_addr hold their last value while fb_we=0.
- A vsync rising edge in the same cycle as an href falling edge: perform line-end processing, then frame end.
- Reset mid-frame: immediate return to IDLE with all outputs cleared; any pending write is lost.

Test Plan:
- Reset/idle: hold rst, then release with arm=0 and stream a full frame → fb_we never asserted, busy=0.
- Single frame: arm=1, continuous=0; send 2 lines of 4 pixels with bytes 0xF8,0x00,0x07,0xE0,... → writes at addr 0,1,2,3 then 320..323; first fb_data=0xF800, second=0x07E0; frame_done pulses once; state DONE; err=0.
- Latency check: second byte of pixel 0 on cam_d at cycle N → fb_we=1 at cycle N+2 with fb_addr=0.
- Over-length line: a line of 322 pixels → 320 writes (addresses 0..319), err=1 and sticky until the next arm entry from IDLE.
- Odd bytes and excess lines: a line with 641 bytes sets err; a frame with 242 lines produces a last write address of 76799 and never writes at 76800 or above.
- Continuous plus mid-frame reset: continuous=1 over 2 frames → 2 frame_done pulses, and addresses restart at 0 each frame; asserting rst mid-line → fb_we=0 the same cycle, busy=0.
